// File: rtl/multi_point_frequency_manager_if.sv
// Pixel stream, run control and register-write readout bundle shared by
// multi_point_frequency_manager and whatever drives or observes it.
interface multi_point_frequency_manager_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] pixel_data;
  logic                  pixel_valid;
  logic                  line_start;
  logic                  start;
  logic                  stop;
  logic                  clear;
  logic                  enable;
  logic [1:0]            register_operation;
  logic [7:0]            register_number;
  logic [31:0]           register_write;
  logic                  irq;

  modport master (
    output pixel_data, pixel_valid, line_start, start, stop, clear,
    input  enable, register_operation, register_number, register_write, irq
  );

  modport slave (
    input  pixel_data, pixel_valid, line_start, start, stop, clear,
    output enable, register_operation, register_number, register_write, irq
  );
endinterface

// File: rtl/multi_point_frequency_manager.sv
// Per-line windowed peak detection on CHANNELS points, period classification
// into F0/F1/unknown counters, and a register-write readout on stop.
module multi_point_frequency_manager #(
  parameter int unsigned              CHANNELS         = 3,
  parameter int unsigned              DATA_WIDTH       = 8,
  parameter int unsigned              DARK_PIXELS      = 16,
  parameter int unsigned              COLOR_PIXELS     = 1024,
  parameter int unsigned              POINT_WIDTH      = 32,
  parameter logic [12*CHANNELS-1:0]   POINT_INDEX      = {12'd768, 12'd256, 12'd2},
  parameter int unsigned              THRESHOLD        = 100,
  parameter logic [16*CHANNELS-1:0]   F0_PERIOD        = {16'd12, 16'd8, 16'd4},
  parameter logic [16*CHANNELS-1:0]   F1_PERIOD        = {16'd14, 16'd10, 16'd6},
  parameter int unsigned              PERIOD_TOLERANCE = 1,
  parameter int unsigned              HOLD_CYCLES      = 4
) (
  input logic                     clock,
  input logic                     reset,
  multi_point_frequency_manager_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DUMP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int unsigned LAST_PIX = DARK_PIXELS + COLOR_PIXELS - 1;
  localparam int unsigned PIX_W    = $clog2(DARK_PIXELS + COLOR_PIXELS);
  localparam int unsigned NREG     = 3 * CHANNELS;
  localparam int unsigned REG_W    = $clog2(NREG);
  localparam int unsigned HOLD_W   = $clog2(HOLD_CYCLES);
  localparam logic [DATA_WIDTH-1:0] THR = DATA_WIDTH'(THRESHOLD);
  localparam logic [15:0]           TOL = 16'(PERIOD_TOLERANCE);

  logic [1:0]                            state_q, state_d;
  logic [PIX_W-1:0]                      pix_q, pix_d, cur_pix;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0]   max_q, max_d;
  logic [CHANNELS-1:0]                   sample_q, sample_d;
  logic [CHANNELS-1:0]                   armed_q, armed_d;
  logic [CHANNELS-1:0][15:0]             line_cnt_q, line_cnt_d;
  logic [CHANNELS-1:0][31:0]             f0_cnt_q, f0_cnt_d;
  logic [CHANNELS-1:0][31:0]             f1_cnt_q, f1_cnt_d;
  logic [CHANNELS-1:0][31:0]             unk_cnt_q, unk_cnt_d;
  logic [REG_W-1:0]                      reg_idx_q, reg_idx_d;
  logic [HOLD_W-1:0]                     hold_q, hold_d;
  logic [CHANNELS-1:0]                   in_win;
  logic                                  clr, enter_run, new_s;
  logic [15:0]                           period;
  logic [31:0]                           rd_val;

  function automatic logic [PIX_W-1:0] win_lo(input int unsigned k);
    return PIX_W'(DARK_PIXELS + 32'(POINT_INDEX[12*k +: 12]));
  endfunction

  function automatic logic [PIX_W-1:0] win_hi(input int unsigned k);
    int unsigned h;
    h = DARK_PIXELS + 32'(POINT_INDEX[12*k +: 12]) + POINT_WIDTH - 1;
    if (h > LAST_PIX) h = LAST_PIX;
    return PIX_W'(h);
  endfunction

  function automatic logic [15:0] absdiff(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] x);
    return (x == '1) ? x : (x + 32'd1);
  endfunction

  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    hold_d     = hold_q;
    max_d      = max_q;
    sample_d   = sample_q;
    armed_d    = armed_q;
    line_cnt_d = line_cnt_q;
    f0_cnt_d   = f0_cnt_q;
    f1_cnt_d   = f1_cnt_q;
    unk_cnt_d  = unk_cnt_q;
    new_s      = 1'b0;
    period     = '0;

    if (bus.line_start)                  cur_pix = '0;
    else if (pix_q == PIX_W'(LAST_PIX))  cur_pix = pix_q;
    else                                 cur_pix = pix_q + PIX_W'(1);
    pix_d = (bus.pixel_valid || bus.line_start) ? cur_pix : pix_q;

    for (int unsigned k = 0; k < CHANNELS; k++)
      in_win[k] = (cur_pix >= win_lo(k)) && (cur_pix <= win_hi(k));

    case (state_q)
      ST_IDLE: if (bus.start && !bus.stop) state_d = ST_RUN;
      ST_RUN: begin
        if (bus.stop) begin
          state_d   = ST_DUMP;
          reg_idx_d = '0;
          hold_d    = '0;
        end
      end
      ST_DUMP: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          hold_d = '0;
          if (reg_idx_q == REG_W'(NREG - 1)) state_d = ST_DONE;
          else                               reg_idx_d = reg_idx_q + REG_W'(1);
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: if (!bus.stop) state_d = ST_IDLE;
    endcase

    clr       = bus.clear && (state_q != ST_DUMP);
    enter_run = (state_q == ST_IDLE) && (state_d == ST_RUN);

    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (clr) begin
        max_d[k]      = '0;
        sample_d[k]   = 1'b0;
        armed_d[k]    = 1'b0;
        line_cnt_d[k] = '0;
        f0_cnt_d[k]   = '0;
        f1_cnt_d[k]   = '0;
        unk_cnt_d[k]  = '0;
      end else if (enter_run) begin
        // Stale maxima from a previous run must not yield a sample on the first line.
        max_d[k]      = '0;
        sample_d[k]   = 1'b0;
        armed_d[k]    = 1'b0;
        line_cnt_d[k] = '0;
      end else if (state_q == ST_RUN) begin
        if (bus.line_start) begin
          new_s         = max_q[k] > THR;
          sample_d[k]   = new_s;
          max_d[k]      = (bus.pixel_valid && in_win[k]) ? bus.pixel_data : '0;
          line_cnt_d[k] = (line_cnt_q[k] == '1) ? line_cnt_q[k] : (line_cnt_q[k] + 16'd1);
          if (new_s && !sample_q[k]) begin
            period        = line_cnt_q[k];
            line_cnt_d[k] = 16'd1;
            armed_d[k]    = 1'b1;
            if (armed_q[k]) begin
              if (period == '1)
                unk_cnt_d[k] = sat_inc(unk_cnt_q[k]);
              else if (absdiff(period, F0_PERIOD[16*k +: 16]) <= TOL)
                f0_cnt_d[k] = sat_inc(f0_cnt_q[k]);
              else if (absdiff(period, F1_PERIOD[16*k +: 16]) <= TOL)
                f1_cnt_d[k] = sat_inc(f1_cnt_q[k]);
              else
                unk_cnt_d[k] = sat_inc(unk_cnt_q[k]);
            end
          end
        end else if (bus.pixel_valid && in_win[k] && (bus.pixel_data > max_q[k])) begin
          max_d[k] = bus.pixel_data;
        end
      end
    end
  end

  // Counters are frozen outside RUN and clear is ignored in DUMP, so reading
  // them directly during DUMP is equivalent to a snapshot taken at DUMP entry.
  always_comb begin
    rd_val = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (reg_idx_q == REG_W'(3*k))     rd_val = f0_cnt_q[k];
      if (reg_idx_q == REG_W'(3*k + 1)) rd_val = f1_cnt_q[k];
      if (reg_idx_q == REG_W'(3*k + 2)) rd_val = unk_cnt_q[k];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      pix_q      <= '0;
      max_q      <= '0;
      sample_q   <= '0;
      armed_q    <= '0;
      line_cnt_q <= '0;
      f0_cnt_q   <= '0;
      f1_cnt_q   <= '0;
      unk_cnt_q  <= '0;
      reg_idx_q  <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      pix_q      <= pix_d;
      max_q      <= max_d;
      sample_q   <= sample_d;
      armed_q    <= armed_d;
      line_cnt_q <= line_cnt_d;
      f0_cnt_q   <= f0_cnt_d;
      f1_cnt_q   <= f1_cnt_d;
      unk_cnt_q  <= unk_cnt_d;
      reg_idx_q  <= reg_idx_d;
      hold_q     <= hold_d;
    end
  end

  assign bus.enable             = (state_q == ST_RUN);
  assign bus.register_operation = (state_q == ST_DUMP) ? 2'd2 : 2'd0;
  assign bus.register_number    = (state_q == ST_DUMP) ? (8'(reg_idx_q) + 8'd1) : 8'd0;
  assign bus.register_write     = (state_q == ST_DUMP) ? rd_val : 32'd0;
  assign bus.irq                = (state_q == ST_DONE);

endmodule

// File: tb/tb_multi_point_frequency_manager.sv
// Directed bench: reset, periodic peaks on windows, threshold/tolerance
// boundaries, clear behaviour, saturation and the timed register readout.
module tb_multi_point_frequency_manager;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] exp_regs [9];

  always #5 clock = ~clock;

  multi_point_frequency_manager_if #(.DATA_WIDTH(8)) bus ();

  multi_point_frequency_manager #(
    .CHANNELS(3),
    .DATA_WIDTH(8),
    .HOLD_CYCLES(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Guards of 255 sit just outside the ch0 window (17, 50) and ch1 window (271, 304).
  function automatic logic [7:0] pix_val(input int unsigned p, input logic [7:0] v0, input logic [7:0] v1);
    if (p == 17 || p == 50 || p == 271 || p == 304) return 8'd255;
    if (p == 49) return v0;
    if (p >= 18 && p < 49) return 8'd1;
    if (p == 272) return v1;
    return 8'd0;
  endfunction

  task automatic send_line(input logic [7:0] v0, input logic [7:0] v1);
    int unsigned last;
    last = (v1 != 8'd0) ? 305 : 51;
    for (int unsigned p = 0; p < last; p++) begin
      @(negedge clock);
      bus.line_start  = (p == 0);
      bus.pixel_valid = 1'b1;
      bus.pixel_data  = pix_val(p, v0, v1);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    bus.line_start  = 1'b0;
    bus.pixel_valid = 1'b0;
  endtask

  task automatic start_run();
    @(negedge clock);
    bus.line_start  = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.start       = 1'b1;
    @(posedge clock); #1;
    chk("run_enable", 32'(bus.enable), 32'd1);
    bus.start = 1'b0;
  endtask

  task automatic do_dump(input bit mid_events);
    @(negedge clock);
    bus.line_start  = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.stop        = 1'b1;
    for (int i = 0; i < 36; i++) begin
      @(posedge clock); #1;
      chk("dump_op",  32'(bus.register_operation), 32'd2);
      chk("dump_num", 32'(bus.register_number), 32'(i / 4 + 1));
      chk("dump_val", bus.register_write, exp_regs[i / 4]);
      chk("dump_irq", 32'(bus.irq), 32'd0);
      if (mid_events && i == 9)  begin bus.stop = 1'b0; bus.clear = 1'b1; end
      if (mid_events && i == 12) bus.clear = 1'b0;
      if (!mid_events && i == 4) bus.start = 1'b1;
      if (!mid_events && i == 7) bus.start = 1'b0;
    end
    @(posedge clock); #1;
    chk("done_irq", 32'(bus.irq), 32'd1);
    chk("done_op",  32'(bus.register_operation), 32'd0);
    chk("done_num", 32'(bus.register_number), 32'd0);
    chk("done_val", bus.register_write, 32'd0);
    chk("done_en",  32'(bus.enable), 32'd0);
    if (!mid_events) begin
      @(posedge clock); #1;
      chk("done_hold_irq", 32'(bus.irq), 32'd1);
      bus.stop = 1'b0;
    end
    @(posedge clock); #1;
    chk("idle_irq", 32'(bus.irq), 32'd0);
    chk("idle_en",  32'(bus.enable), 32'd0);
  endtask

  initial begin
    bus.pixel_data  = '0;
    bus.pixel_valid = 1'b0;
    bus.line_start  = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.clear       = 1'b0;

    // Reset held while every input toggles
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      bus.pixel_valid = i[0];
      bus.line_start  = i[1];
      bus.start       = ~i[0];
      bus.stop        = i[2];
      bus.clear       = i[0];
      bus.pixel_data  = 8'(i * 37);
      @(posedge clock); #1;
      chk("rst_enable", 32'(bus.enable), 32'd0);
      chk("rst_op",     32'(bus.register_operation), 32'd0);
      chk("rst_irq",    32'(bus.irq), 32'd0);
    end
    chk("rst_num", 32'(bus.register_number), 32'd0);
    chk("rst_val", bus.register_write, 32'd0);

    @(negedge clock);
    reset = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.line_start  = 1'b0;
    bus.clear       = 1'b0;
    bus.start       = 1'b1;
    bus.stop        = 1'b1;
    @(posedge clock); #1;
    chk("stop_priority", 32'(bus.enable), 32'd0);
    bus.stop = 1'b0;
    @(posedge clock); #1;
    chk("start_enable", 32'(bus.enable), 32'd1);
    bus.start = 1'b0;

    // Channel 0 peak every 4th line for 40 lines
    for (int n = 0; n < 40; n++)
      send_line((n % 4 == 0) ? 8'd200 : 8'd0, 8'd0);
    @(posedge clock); #1;
    chk("run_op_idle", 32'(bus.register_operation), 32'd0);
    exp_regs = '{32'd9, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    do_dump(1'b0);

    // Clear in IDLE, then tolerance edges on ch0 and threshold edges on ch1
    @(negedge clock);
    bus.clear = 1'b1;
    @(negedge clock);
    bus.clear = 1'b0;
    start_run();
    for (int n = 0; n < 42; n++) begin
      logic [7:0] v0, v1;
      v0 = (n == 0 || n == 5 || n == 12 || n == 15 || n == 23) ? 8'd200 : 8'd0;
      v1 = (n == 0 || n == 10 || n == 20 || n == 40) ? 8'd101 : ((n == 30) ? 8'd100 : 8'd0);
      send_line(v0, v1);
    end
    @(posedge clock); #1;
    chk("run2_enable", 32'(bus.enable), 32'd1);
    exp_regs = '{32'd2, 32'd1, 32'd1, 32'd0, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0};
    do_dump(1'b1);

    // Clear mid-RUN, re-armed suppression, then f1 saturation on ch1
    start_run();
    for (int n = 0; n < 48; n++) begin
      logic [7:0] v0, v1;
      v0 = (n <= 24 && n % 4 == 0) ? 8'd200 : 8'd0;
      v1 = (n == 16 || n == 26 || n == 36 || n == 46) ? 8'd150 : 8'd0;
      send_line(v0, v1);
      if (n == 14) begin
        idle_cycle();
        bus.clear = 1'b1;
        @(posedge clock); #1;
        chk("clear_keeps_run", 32'(bus.enable), 32'd1);
        bus.clear = 1'b0;
      end
      if (n == 27) begin
        idle_cycle();
        force dut.f1_cnt_q = {32'h0, 32'hFFFF_FFFE, 32'h0};
        @(posedge clock); #1;
        release dut.f1_cnt_q;
      end
    end
    exp_regs = '{32'd2, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0};
    do_dump(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
